// File: rtl/ace_snoop_responder_if.sv
// ACE snoop channel bundle (AC request, CR response, CD data) between the CCU and a cached master.
// The CCU side uses the master modport and the snoop responder uses the slave modport.
interface ace_snoop_responder_if #(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 64
);
   logic [AddrWidth-1:0] ac_addr;
   logic [3:0]           ac_snoop;
   logic [2:0]           ac_prot;
   logic                 ac_valid;
   logic                 ac_ready;
   logic                 cr_valid;
   logic                 cr_ready;
   logic [4:0]           cr_resp;
   logic                 cd_valid;
   logic                 cd_ready;
   logic [DataWidth-1:0] cd_data;
   logic                 cd_last;

   modport master (
      output ac_addr, ac_snoop, ac_prot, ac_valid, cr_ready, cd_ready,
      input  ac_ready, cr_valid, cr_resp, cd_valid, cd_data, cd_last
   );

   modport slave (
      input  ac_addr, ac_snoop, ac_prot, ac_valid, cr_ready, cd_ready,
      output ac_ready, cr_valid, cr_resp, cd_valid, cd_data, cd_last
   );
endinterface

// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: AC accept, tag lookup, CR response, CD burst and line-state update.
// Define ACE_SNOOP_ERR_EN to answer unsupported snoop opcodes with an Error response.
module ace_snoop_responder #(
   parameter int  NoBeats   = 4,
   parameter int  DataWidth = 64,
   parameter int  AddrWidth = 32,
   localparam int BeatWidth = (NoBeats > 1) ? $clog2(NoBeats) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   ace_snoop_responder_if.slave snoop_io,
   output logic                 lkp_valid_o,
   output logic [AddrWidth-1:0] lkp_addr_o,
   input  logic                 lkp_ready_i,
   input  logic                 lkp_hit_i,
   input  logic                 lkp_dirty_i,
   input  logic                 lkp_shared_i,
   output logic                 rd_valid_o,
   output logic [BeatWidth-1:0] rd_beat_o,
   input  logic                 rd_ready_i,
   input  logic [DataWidth-1:0] rd_data_i,
   output logic                 upd_valid_o,
   output logic                 upd_inval_o,
   output logic                 upd_clean_o,
   input  logic                 upd_ready_i
);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StLookup = 3'd1;
   localparam logic [2:0] StResp   = 3'd2;
   localparam logic [2:0] StData   = 3'd3;
   localparam logic [2:0] StUpdate = 3'd4;

   localparam logic [3:0] OpReadOnce     = 4'b0000;
   localparam logic [3:0] OpReadShared   = 4'b0001;
   localparam logic [3:0] OpReadUnique   = 4'b0111;
   localparam logic [3:0] OpCleanShared  = 4'b1000;
   localparam logic [3:0] OpCleanInvalid = 4'b1001;
   localparam logic [3:0] OpMakeInvalid  = 4'b1101;

`ifdef ACE_SNOOP_ERR_EN
   localparam logic [4:0] UnsupportedResp = 5'b00010;
`else
   localparam logic [4:0] UnsupportedResp = 5'b00000;
`endif

   localparam logic [BeatWidth-1:0] LastBeatIdx = BeatWidth'(NoBeats - 1);

   logic [2:0]           state_q,    state_d;
   logic [AddrWidth-1:0] acAddr_q,   acAddr_d;
   logic [3:0]           acSnoop_q,  acSnoop_d;
   logic [2:0]           acProt_q,   acProt_d;
   logic [4:0]           crResp_q,   crResp_d;
   logic                 needUpd_q,  needUpd_d;
   logic                 updInval_q, updInval_d;
   logic                 updClean_q, updClean_d;
   logic [BeatWidth-1:0] beatCnt_q,  beatCnt_d;
   logic [DataWidth-1:0] beatData_q, beatData_d;
   logic                 beatFull_q, beatFull_d;

   logic opSupported;
   logic lastBeat;
   logic hitDt, hitPd, hitIs, hitUpd, hitInv, hitCln;
   logic unusedProt;

   // Protection bits are kept with the request; nothing downstream consumes them yet.
   assign unusedProt = ^acProt_q;
   assign lastBeat   = (beatCnt_q == LastBeatIdx);

   always_comb begin
      case (snoop_io.ac_snoop)
         OpReadOnce, OpReadShared, OpReadUnique,
         OpCleanShared, OpCleanInvalid, OpMakeInvalid: opSupported = 1'b1;
         default:                                      opSupported = 1'b0;
      endcase
   end

   // Response and update intent for a hit, from the latched opcode and the current lookup result.
   always_comb begin
      hitDt  = 1'b0;
      hitPd  = 1'b0;
      hitIs  = 1'b0;
      hitUpd = 1'b0;
      hitInv = 1'b0;
      hitCln = 1'b0;
      case (acSnoop_q)
         OpReadOnce: begin
            hitDt = 1'b1;
            hitIs = 1'b1;
         end
         OpReadShared: begin
            hitDt  = 1'b1;
            hitIs  = 1'b1;
            hitPd  = lkp_dirty_i;
            hitUpd = 1'b1;
            hitCln = 1'b1;
         end
         OpReadUnique: begin
            hitDt  = 1'b1;
            hitPd  = lkp_dirty_i;
            hitUpd = 1'b1;
            hitInv = 1'b1;
         end
         OpCleanShared: begin
            hitDt  = lkp_dirty_i;
            hitPd  = lkp_dirty_i;
            hitIs  = 1'b1;
            hitUpd = lkp_dirty_i;
            hitCln = lkp_dirty_i;
         end
         OpCleanInvalid: begin
            hitDt  = lkp_dirty_i;
            hitPd  = lkp_dirty_i;
            hitUpd = 1'b1;
            hitInv = 1'b1;
         end
         OpMakeInvalid: begin
            hitUpd = 1'b1;
            hitInv = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      acAddr_d   = acAddr_q;
      acSnoop_d  = acSnoop_q;
      acProt_d   = acProt_q;
      crResp_d   = crResp_q;
      needUpd_d  = needUpd_q;
      updInval_d = updInval_q;
      updClean_d = updClean_q;
      beatCnt_d  = beatCnt_q;
      beatData_d = beatData_q;
      beatFull_d = beatFull_q;
      case (state_q)
         StIdle: begin
            if (snoop_io.ac_valid) begin
               acAddr_d   = snoop_io.ac_addr;
               acSnoop_d  = snoop_io.ac_snoop;
               acProt_d   = snoop_io.ac_prot;
               beatCnt_d  = '0;
               beatFull_d = 1'b0;
               if (opSupported) begin
                  state_d = StLookup;
               end else begin
                  crResp_d   = UnsupportedResp;
                  needUpd_d  = 1'b0;
                  updInval_d = 1'b0;
                  updClean_d = 1'b0;
                  state_d    = StResp;
               end
            end
         end
         StLookup: begin
            if (lkp_ready_i) begin
               crResp_d   = lkp_hit_i ? {~lkp_shared_i, hitIs, hitPd, 1'b0, hitDt} : 5'b00000;
               needUpd_d  = lkp_hit_i & hitUpd;
               updInval_d = lkp_hit_i & hitInv;
               updClean_d = lkp_hit_i & hitCln;
               state_d    = StResp;
            end
         end
         StResp: begin
            if (snoop_io.cr_ready) begin
               if (crResp_q[0])    state_d = StData;
               else if (needUpd_q) state_d = StUpdate;
               else                state_d = StIdle;
            end
         end
         StData: begin
            // One-entry beat buffer: the next read is only issued once the held beat is handed off.
            if (!beatFull_q) begin
               if (rd_ready_i) begin
                  beatData_d = rd_data_i;
                  beatFull_d = 1'b1;
               end
            end else if (snoop_io.cd_ready) begin
               beatFull_d = 1'b0;
               if (lastBeat) begin
                  beatCnt_d = '0;
                  state_d   = needUpd_q ? StUpdate : StIdle;
               end else begin
                  beatCnt_d = beatCnt_q + 1'b1;
               end
            end
         end
         StUpdate: begin
            if (upd_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         acAddr_q   <= '0;
         acSnoop_q  <= '0;
         acProt_q   <= '0;
         crResp_q   <= '0;
         needUpd_q  <= 1'b0;
         updInval_q <= 1'b0;
         updClean_q <= 1'b0;
         beatCnt_q  <= '0;
         beatData_q <= '0;
         beatFull_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         acAddr_q   <= acAddr_d;
         acSnoop_q  <= acSnoop_d;
         acProt_q   <= acProt_d;
         crResp_q   <= crResp_d;
         needUpd_q  <= needUpd_d;
         updInval_q <= updInval_d;
         updClean_q <= updClean_d;
         beatCnt_q  <= beatCnt_d;
         beatData_q <= beatData_d;
         beatFull_q <= beatFull_d;
      end
   end

   assign snoop_io.ac_ready = (state_q == StIdle);
   assign snoop_io.cr_valid = (state_q == StResp);
   assign snoop_io.cr_resp  = (state_q == StResp) ? crResp_q : 5'b00000;
   assign snoop_io.cd_valid = (state_q == StData) && beatFull_q;
   assign snoop_io.cd_last  = snoop_io.cd_valid && lastBeat;
   assign snoop_io.cd_data  = snoop_io.cd_valid ? beatData_q : '0;

   assign lkp_valid_o = (state_q == StLookup);
   assign lkp_addr_o  = acAddr_q;
   assign rd_valid_o  = (state_q == StData) && !beatFull_q;
   assign rd_beat_o   = beatCnt_q;
   assign upd_valid_o = (state_q == StUpdate);
   assign upd_inval_o = (state_q == StUpdate) && updInval_q;
   assign upd_clean_o = (state_q == StUpdate) && updClean_q;

endmodule
